sram_arbiter: RTL and testbench

Single-port arbiter sharing the 4096x8 image SRAM between three requesters: the input loader (writes), the barcode decoder (reads) and the convolution engine (reads). It sits between those engines and the SRAM macro and replaces the phase-based mux in the top level. The SRAM pin drive is registered, read data is routed back with a per-requester response strobe, and one request is accepted per cycle.

---
 rtl/sram_arbiter_pkg.sv | 46 ++++
 rtl/sram_arbiter_if.sv | 29 ++
 rtl/sram_arbiter_arb_grant.sv | 46 ++++
 rtl/sram_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_pkg
// Description : Shared constants, types and helpers for the image-SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int REQ_ID_W = 2;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_LOAD = 2'd0;
    localparam req_id_t REQ_BAR  = 2'd1;
    localparam req_id_t REQ_CONV = 2'd2;

    // Tag carried alongside each read while it travels through the SRAM.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

    function automatic int addr_lsb(input int n);
        return n * ADDR_W;
    endfunction

    function automatic int data_lsb(input int n);
        return n * DATA_W;
    endfunction

    function automatic req_id_t grant_to_id(input logic [NUM_REQ-1:0] grant);
        req_id_t id;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                id = req_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Requester-side request/response bundle of the SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
;
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [NUM_REQ-1:0]        i_req_we;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*DATA_W-1:0] i_req_wdata;
    logic [NUM_REQ-1:0]        o_rsp_valid;
    logic [DATA_W-1:0]         o_rsp_data;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata,
        input  o_req_ready, o_rsp_valid, o_rsp_data
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata,
        output o_req_ready, o_rsp_valid, o_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/sram_arbiter_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant
// Description : Combinational one-hot grant; rotating priority from i_ptr when
//               SRAM_ARB_RR_EN is defined, otherwise fixed priority 0 > 1 > 2.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_grant
    import sram_arbiter_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] i_valid,
`ifdef SRAM_ARB_RR_EN
    input  wire req_id_t            i_ptr,
`endif
    output logic [NUM_REQ-1:0]      o_grant
);

    req_id_t w_base;

`ifdef SRAM_ARB_RR_EN
    assign w_base = i_ptr;
`else
    assign w_base = '0;
`endif

    // Scan starts at w_base and wraps; first valid slot wins.
    always_comb begin
        logic found;
        int   slot;
        found   = 1'b0;
        slot    = 0;
        o_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = int'(w_base) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!found && i_valid[slot[REQ_ID_W-1:0]]) begin
                o_grant[slot[REQ_ID_W-1:0]] = 1'b1;
                found                       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares the 4096x8 image SRAM between loader, barcode decoder
//               and convolution engine. Round-robin with SRAM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    sram_arbiter_if.slave          bus,
    output logic                   o_sram_cen,
    output logic                   o_sram_wen,
    output logic [ADDR_W-1:0]      o_sram_addr,
    output logic [DATA_W-1:0]      o_sram_d,
    input  wire logic [DATA_W-1:0] i_sram_q,
    output logic                   o_busy
);

    logic [NUM_REQ-1:0] w_req_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    req_id_t            w_sel_id;

    logic               sram_cen_q,  sram_cen_d;
    logic               sram_wen_q,  sram_wen_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]  sram_d_q,    sram_d_d;
    rd_tag_t            tag1_q,      tag1_d;
    rd_tag_t            tag2_q;

    // Nothing is granted while reset is held, so ready reads 0 during reset.
    assign w_req_valid = bus.i_req_valid & {NUM_REQ{i_rst_n}};

`ifdef SRAM_ARB_RR_EN
    req_id_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (w_accept) begin
            ptr_d = (w_sel_id == req_id_t'(NUM_REQ-1)) ? '0 : req_id_t'(w_sel_id + req_id_t'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    arb_grant u_grant (
        .i_valid (w_req_valid),
        .i_ptr   (ptr_q),
        .o_grant (w_grant)
    );
`else
    arb_grant u_grant (
        .i_valid (w_req_valid),
        .o_grant (w_grant)
    );
`endif

    assign w_accept        = |w_grant;
    assign bus.o_req_ready = w_grant;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = w_sel_we    | bus.i_req_we[i];
                w_sel_addr  = w_sel_addr  | bus.i_req_addr[addr_lsb(i) +: ADDR_W];
                w_sel_wdata = w_sel_wdata | bus.i_req_wdata[data_lsb(i) +: DATA_W];
            end
        end
        w_sel_id = grant_to_id(w_grant);
    end

    // Address and data hold on idle cycles to avoid needless pin toggling.
    always_comb begin
        sram_cen_d  = ~w_accept;
        sram_wen_d  = ~(w_accept & w_sel_we);
        sram_addr_d = w_accept ? w_sel_addr  : sram_addr_q;
        sram_d_d    = w_accept ? w_sel_wdata : sram_d_q;
        tag1_d.vld  = w_accept & ~w_sel_we;
        tag1_d.id   = w_sel_id;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sram_cen_q  <= 1'b1;
            sram_wen_q  <= 1'b1;
            sram_addr_q <= '0;
            sram_d_q    <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
        end else begin
            sram_cen_q  <= sram_cen_d;
            sram_wen_q  <= sram_wen_d;
            sram_addr_q <= sram_addr_d;
            sram_d_q    <= sram_d_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
        end
    end

    // tag2 lines up with the cycle the SRAM drives the read data.
    always_comb begin
        bus.o_rsp_valid = '0;
        if (tag2_q.vld) begin
            bus.o_rsp_valid[tag2_q.id] = 1'b1;
        end
    end

    assign bus.o_rsp_data = i_sram_q;
    assign o_sram_cen     = sram_cen_q;
    assign o_sram_wen     = sram_wen_q;
    assign o_sram_addr    = sram_addr_q;
    assign o_sram_d       = sram_d_q;
    assign o_busy         = tag1_q.vld | tag2_q.vld;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cen, wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] q;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int rsp_cnt [NUM_REQ] = '{default: 0};

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_sram_cen  (cen),
        .o_sram_wen  (wen),
        .o_sram_addr (addr),
        .o_sram_d    (d),
        .i_sram_q    (q),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (!cen) begin
            if (!wen) mem[addr] <= d;
            else      q         <= mem[addr];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.o_rsp_valid[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bus.i_req_valid[n]                  = v;
        bus.i_req_we[n]                     = we;
        bus.i_req_addr[n*ADDR_W +: ADDR_W]  = a;
        bus.i_req_wdata[n*DATA_W +: DATA_W] = wd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, base1;
        logic [NUM_REQ-1:0] exp_g;
        int g1;

        rst_n           = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_we    = '0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;

        // Reset values and idle behaviour
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pins", {cen, wen, addr, d}, {1'b1, 1'b1, 12'h000, 8'h00});
        check_eq("rst_ready", bus.o_req_ready, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle", {cen, wen, addr, bus.o_req_ready, bus.o_rsp_valid, busy},
                     {1'b1, 1'b1, 12'h000, 3'b000, 3'b000, 1'b0});
        end

        // Write 0x5A to 0x000 from loader, read it back from barcode decoder
        base0 = rsp_cnt[0];
        base1 = rsp_cnt[1];
        set_req(0, 1'b1, 1'b1, 12'h000, 8'h5A);
        #1 check_eq("wr_ready", bus.o_req_ready, 3'b001);
        step();
        set_req(0, 1'b0, 1'b0, 12'h000, 8'h00);
        set_req(1, 1'b1, 1'b0, 12'h000, 8'h00);
        #1 check_eq("wr_pins", {cen, wen, addr, d}, {1'b0, 1'b0, 12'h000, 8'h5A});
        check_eq("rd_ready", bus.o_req_ready, 3'b010);
        step();
        set_req(1, 1'b0, 1'b0, 12'h000, 8'h00);
        #1 check_eq("rd_pins", {cen, wen, addr}, {1'b0, 1'b1, 12'h000});
        check_eq("rd_t1_rsp", {bus.o_rsp_valid, busy}, {3'b000, 1'b1});
        step();
        check_eq("rd_t2_rsp", {bus.o_rsp_valid, busy}, {3'b010, 1'b1});
        check_eq("rd_t2_data", bus.o_rsp_data, 8'h5A);
        check_eq("rd_t2_cen", cen, 1'b1);
        step();
        check_eq("rd_t3_rsp", {bus.o_rsp_valid, busy}, {3'b000, 1'b0});
        step();
        check_eq("rsp0_never", rsp_cnt[0] - base0, 0);
        check_eq("rsp1_once", rsp_cnt[1] - base1, 1);

        // All three requesters valid for nine cycles
        do_reset();
        g1 = 0;
        for (int n = 0; n < NUM_REQ; n++) set_req(n, 1'b1, 1'b0, 12'h100, 8'h00);
        for (int i = 0; i < 9; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_g = 3'b001 << (i % 3);
`else
            exp_g = 3'b001;
`endif
            #1 check_eq($sformatf("contend_%0d", i), bus.o_req_ready, exp_g);
            if (bus.o_req_ready[1]) g1++;
            step();
        end
        bus.i_req_valid = '0;
`ifdef SRAM_ARB_RR_EN
        check_eq("contend_g1", g1, 3);
`else
        check_eq("contend_g1", g1, 0);
`endif
        #1 check_eq("drain_ready", bus.o_req_ready, 3'b000);
        repeat (3) step();
        check_eq("drain_idle", {cen, bus.o_rsp_valid, busy}, {1'b1, 3'b000, 1'b0});

        // Preload 0x10..0x13, then back-to-back reads from convolution engine
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 1'b1, 12'h010 + 12'(i), 8'h10 + 8'(i));
            #1 check_eq($sformatf("pre_ready_%0d", i), bus.o_req_ready, 3'b001);
            step();
        end
        set_req(0, 1'b0, 1'b0, 12'h000, 8'h00);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_req(2, 1'b1, 1'b0, 12'h010 + 12'(i), 8'h00);
            else       set_req(2, 1'b0, 1'b0, 12'h000, 8'h00);
            #1;
            if (i < 4) check_eq($sformatf("b2b_ready_%0d", i), bus.o_req_ready, 3'b100);
            if (i < 2) begin
                check_eq($sformatf("b2b_rsp_%0d", i), bus.o_rsp_valid, 3'b000);
            end else begin
                check_eq($sformatf("b2b_rsp_%0d", i), bus.o_rsp_valid, 3'b100);
                check_eq($sformatf("b2b_data_%0d", i), bus.o_rsp_data, 8'h10 + 8'(i - 2));
            end
            step();
        end
        check_eq("b2b_end", bus.o_rsp_valid, 3'b000);

        // Reset in the cycle after a read is accepted
        set_req(1, 1'b1, 1'b0, 12'h011, 8'h00);
        #1 check_eq("mid_ready", bus.o_req_ready, 3'b010);
        step();
        set_req(1, 1'b0, 1'b0, 12'h000, 8'h00);
        check_eq("mid_pins", {cen, busy}, {1'b0, 1'b1});
        base1 = rsp_cnt[1];
        rst_n = 1'b0;
        #1 check_eq("mid_rst_now", {cen, wen, busy, bus.o_rsp_valid}, {1'b1, 1'b1, 1'b0, 3'b000});
        step();
        check_eq("mid_rst_t2", bus.o_rsp_valid, 3'b000);
        rst_n = 1'b1;
        repeat (4) step();
        check_eq("mid_no_rsp", rsp_cnt[1] - base1, 0);

        // Barcode decoder holds its request while the loader wins
        set_req(0, 1'b1, 1'b1, 12'h020, 8'h77);
        set_req(1, 1'b1, 1'b0, 12'h033, 8'h00);
        #1 check_eq("hold_ready0", bus.o_req_ready, 3'b001);
        step();
        set_req(0, 1'b0, 1'b0, 12'h000, 8'h00);
        #1 check_eq("hold_ready1", bus.o_req_ready, 3'b010);
        check_eq("hold_pins0", {cen, wen, addr, d}, {1'b0, 1'b0, 12'h020, 8'h77});
        step();
        set_req(1, 1'b0, 1'b0, 12'h000, 8'h00);
        #1 check_eq("hold_pins1", {cen, wen, addr}, {1'b0, 1'b1, 12'h033});
        step();
        check_eq("hold_single", {cen, wen, addr}, {1'b1, 1'b1, 12'h033});
        check_eq("hold_rsp", bus.o_rsp_valid, 3'b010);
        step();
        check_eq("hold_end", {cen, bus.o_rsp_valid, busy}, {1'b1, 3'b000, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
